// File: rtl/pc_redirect_unit.sv
// Program counter owner: redirect target selection, pending redirect, fetch request.
// Optional PC_DELAY_SLOT_EN: branch/jump/eret redirects leave the delay slot unsquashed.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic [5:0]  id_op,
    input  logic [5:0]  id_func,
    input  logic [31:0] id_pc,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_index,
    input  logic [31:0] rs_value,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        if_flush,
    output logic        redirect_busy
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

`ifdef PC_DELAY_SLOT_EN
    localparam logic BR_FLUSH = 1'b0;
`else
    localparam logic BR_FLUSH = 1'b1;
`endif

    typedef enum logic {RUN, PEND} state_t;

    state_t      state;
    logic [31:0] pend_tgt;
    logic [31:0] id_pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] tgt;
    logic        is_bcond;
    logic        is_jump;
    logic        is_jreg;

    always_comb begin
        id_pc_plus4 = id_pc + 32'd4;
        br_tgt      = id_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
        is_bcond    = (id_op == OP_BEQ) || (id_op == OP_BNE) || (id_op == OP_REGIMM);
        is_jump     = (id_op == OP_J) || (id_op == OP_JAL);
        is_jreg     = (id_op == OP_SPECIAL) &&
                      ((id_func == FN_JR) || (id_func == FN_JALR));
        tgt = id_pc_plus4;
        if (exception)     tgt = EXC_VECTOR;
        else if (is_bcond) tgt = br_tgt;
        else if (is_jump)  tgt = {id_pc_plus4[31:28], id_index, 2'b00};
        else if (is_jreg)  tgt = rs_value;
    end

    // Flush marks the cycle whose edge actually loads a new target.
    always_comb begin
        if_flush = 1'b0;
        if (!rst) begin
            if (exception)          if_flush = 1'b1;
            else if (eret)          if_flush = !stall && BR_FLUSH;
            else if (state == PEND) if_flush = !stall && BR_FLUSH;
            else if (branch)        if_flush = !stall && BR_FLUSH;
        end
    end

    assign imem_req      = !rst;
    assign redirect_busy = (state == PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            state    <= RUN;
            pend_tgt <= 32'd0;
        end else if (exception) begin
            pc       <= EXC_VECTOR;
            pend_tgt <= EXC_VECTOR;
            state    <= RUN;
        end else if (eret) begin
            if (stall) begin
                pend_tgt <= epc;
                state    <= PEND;
            end else begin
                pc    <= epc;
                state <= RUN;
            end
        end else if (state == PEND) begin
            // ID still holds the same instruction, so a repeated branch is ignored.
            if (!stall) begin
                pc    <= pend_tgt;
                state <= RUN;
            end
        end else if (branch) begin
            if (stall) begin
                pend_tgt <= tgt;
                state    <= PEND;
            end else begin
                pc <= tgt;
            end
        end else if (imem_ready && !stall) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with an expectation queue.
module tb_pc_redirect_unit;

`ifdef PC_DELAY_SLOT_EN
    localparam logic BF = 1'b0;
`else
    localparam logic BF = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, branch, exception, eret, imem_ready;
    logic [31:0] epc, id_pc, rs_value;
    logic [5:0]  id_op, id_func;
    logic [15:0] id_imm16;
    logic [25:0] id_index;
    logic [31:0] pc;
    logic        imem_req, if_flush, redirect_busy;

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        req;
        logic        busy;
    } exp_t;

    exp_t sb[$];

    pc_redirect_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch),
        .exception(exception), .eret(eret), .epc(epc),
        .id_op(id_op), .id_func(id_func), .id_pc(id_pc),
        .id_imm16(id_imm16), .id_index(id_index), .rs_value(rs_value),
        .imem_ready(imem_ready), .pc(pc), .imem_req(imem_req),
        .if_flush(if_flush), .redirect_busy(redirect_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        ntot++;
        assert (obs === want) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    // Pre-edge: flush/req; post-edge: pc/busy.
    task automatic cyc(input string tag, input logic [31:0] want_pc,
                       input logic want_fl, input logic want_bz);
        exp_t e, g;
        logic fo, ro;
        e.tag = tag; e.pc = want_pc; e.flush = want_fl;
        e.req = !rst; e.busy = want_bz;
        sb.push_back(e);
        #1;
        fo = if_flush;
        ro = imem_req;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk({g.tag, ".pc"}, pc, g.pc);
        chk({g.tag, ".busy"}, {31'd0, redirect_busy}, {31'd0, g.busy});
        chk({g.tag, ".flush"}, {31'd0, fo}, {31'd0, g.flush});
        chk({g.tag, ".req"}, {31'd0, ro}, {31'd0, g.req});
    endtask

    task automatic clr();
        branch = 0; exception = 0; eret = 0;
        id_op = 6'h3f; id_func = 0; id_pc = 0;
        id_imm16 = 0; id_index = 0; rs_value = 0; epc = 0;
    endtask

    initial begin
        rst = 1; stall = 0; imem_ready = 1;
        clr();
        cyc("rst0", 32'h00400000, 0, 0);
        cyc("rst1", 32'h00400000, 0, 0);
        rst = 0;
        cyc("run1", 32'h00400004, 0, 0);
        cyc("run2", 32'h00400008, 0, 0);

        branch = 1; id_op = 6'h04; id_pc = 32'h00400010; id_imm16 = 16'hFFFC;
        cyc("beq", 32'h00400004, BF, 0);
        clr();

        branch = 1; stall = 1; id_op = 6'h00; id_func = 6'h08;
        rs_value = 32'h00400100;
        cyc("jr_st1", 32'h00400004, 0, 1);
        cyc("jr_st2", 32'h00400004, 0, 1);
        cyc("jr_st3", 32'h00400004, 0, 1);
        stall = 0;
        cyc("jr_go", 32'h00400100, BF, 0);
        clr();
        cyc("jr_seq", 32'h00400104, 0, 0);

        branch = 1; stall = 1; id_op = 6'h02;
        id_pc = 32'h00400104; id_index = 26'h0100080;
        cyc("j_pend", 32'h00400104, 0, 1);
        exception = 1;
        cyc("exc_pend", 32'h00400004, 1, 0);
        clr(); stall = 0;
        cyc("exc_seq", 32'h00400008, 0, 0);

        eret = 1; exception = 1; branch = 1; epc = 32'h00400200;
        cyc("eret_exc", 32'h00400004, 1, 0);
        exception = 0; branch = 0;
        cyc("eret", 32'h00400200, BF, 0);
        clr();
        cyc("eret_seq", 32'h00400204, 0, 0);

        imem_ready = 0;
        cyc("bp1", 32'h00400204, 0, 0);
        cyc("bp2", 32'h00400204, 0, 0);
        branch = 1; id_op = 6'h02; id_pc = 32'h00400200; id_index = 26'h0100040;
        cyc("bp_j", 32'h00400100, BF, 0);
        clr();
        cyc("bp4", 32'h00400100, 0, 0);
        imem_ready = 1;
        cyc("bp_rel", 32'h00400104, 0, 0);

        branch = 1; id_op = 6'h05; id_pc = 32'h00400100; id_imm16 = 16'h0010;
        cyc("bne", 32'h00400144, BF, 0);
        clr();
        cyc("bne_seq", 32'h00400148, 0, 0);

        branch = 1; id_op = 6'h01; id_pc = 32'hFFFFFFF8; id_imm16 = 16'h0004;
        cyc("bgez_wrap", 32'h0000000C, BF, 0);
        clr();
        cyc("wrap_seq", 32'h00000010, 0, 0);

        branch = 1; stall = 1; id_op = 6'h00; id_func = 6'h09;
        rs_value = 32'h00400300;
        cyc("jalr_pend", 32'h00000010, 0, 1);
        rst = 1;
        cyc("rst_pend", 32'h00400000, 0, 0);
        rst = 0; stall = 0;
        clr();
        cyc("rst_drop", 32'h00400004, 0, 0);

        eret = 1; stall = 1; epc = 32'h00400200;
        cyc("eret_st", 32'h00400004, 0, 1);
        stall = 0;
        cyc("eret_go", 32'h00400200, BF, 0);
        clr();
        cyc("eret_go_seq", 32'h00400204, 0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
